// File: rtl/dsp_pkg.sv
// Shared defaults and read-FSM encoding for the ping-pong frame buffer.
package dsp_pkg;
  localparam int unsigned DATA_WIDTH_DEF = 12;
  localparam int unsigned FRAME_LEN_DEF  = 256;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_LOAD   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;
endpackage

// File: rtl/pingpong_bank_ram.sv
// Two-bank sample store: one write port, one registered read port.
module pingpong_bank_ram
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_bank,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int unsigned DEPTH = 1 << (ADDR_W + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Read register doubles as the streamed output sample, so it is cleared with frame state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (clear) rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end
endmodule

// File: rtl/pingpong_frame_ctrl.sv
// Ping-pong frame buffer: ADC samples fill alternating banks, full banks stream out with ready/valid.
module pingpong_frame_ctrl
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sample,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  out_last,
  output logic [1:0]            bank_full,
  output logic                  overflow,
  output logic [15:0]           frames_done
);
  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  rd_state_e        state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             wr_bank, rd_bank;

  logic             wr_acc, wr_last, xfer, rd_last, rd_en;
  logic [CNT_W-1:0] rd_addr;
  logic [1:0]       bank_full_nxt;

  // Handshake decode, bank flag update and read-FSM next state.
  always_comb begin
    state_nxt     = state;
    wr_acc        = in_valid & ~bank_full[wr_bank];
    wr_last       = wr_acc & (wr_cnt == CNT_LAST);
    xfer          = out_valid & out_ready;
    rd_last       = xfer & out_last;
    rd_en         = 1'b0;
    rd_addr       = rd_cnt + CNT_W'(1);
    bank_full_nxt = bank_full;
    if (wr_last) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_last) bank_full_nxt[rd_bank] = 1'b0;
    case (state)
      RD_IDLE: begin
        if (bank_full[rd_bank]) state_nxt = RD_LOAD;
      end
      RD_LOAD: begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        // Prefetch the next sample during a transfer to sustain one sample per cycle.
        rd_en = xfer & ~out_last;
        if (rd_last) state_nxt = RD_IDLE;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= RD_IDLE;
    else if (flush) state <= RD_IDLE;
    else            state <= state_nxt;
  end

  // Write-side and read-side frame bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt      <= '0;
      wr_bank     <= 1'b0;
      rd_cnt      <= '0;
      rd_bank     <= 1'b0;
      bank_full   <= 2'b00;
      overflow    <= 1'b0;
      frames_done <= '0;
    end else if (flush) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_acc) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + CNT_W'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (in_valid && bank_full[wr_bank]) overflow <= 1'b1;
      if (xfer) rd_cnt <= rd_last ? '0 : rd_cnt + CNT_W'(1);
      if (rd_last) begin
        rd_bank     <= ~rd_bank;
        frames_done <= frames_done + 16'd1;
      end
    end
  end

  // Output qualifiers track the sample currently held in the read register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= (state_nxt == RD_STREAM);
      if (rd_last)    out_last <= 1'b0;
      else if (rd_en) out_last <= (rd_addr == CNT_LAST);
    end
  end

  pingpong_bank_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_W    (CNT_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .wr_en  (wr_acc & ~flush),
    .wr_bank(wr_bank),
    .wr_addr(wr_cnt),
    .wr_data(in_sample),
    .rd_en  (rd_en & ~flush),
    .rd_bank(rd_bank),
    .rd_addr(rd_addr),
    .rd_data(out_sample)
  );
endmodule

// File: tb/tb_pingpong_frame_ctrl.sv
// Self-checking bench: scenario table plus a frame scoreboard fed by a write-side model.
module tb_pingpong_frame_ctrl;
  localparam int unsigned DW = 12;
  localparam int unsigned FL = 256;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [DW-1:0] in_sample, out_sample;
  logic          out_valid, out_last, overflow;
  logic [1:0]    bank_full;
  logic [15:0]   frames_done;

  always #5 clk = ~clk;

  pingpong_frame_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_last   (out_last),
    .bank_full  (bank_full),
    .overflow   (overflow),
    .frames_done(frames_done)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  // ready_mode: 0 always ready, 1 stalled during input then ready, 2 toggling.
  // abort: 0 none, 1 flush after 100 samples, 2 reset after 100 samples.
  typedef struct {
    int         n_in;
    int         ready_mode;
    int         abort;
    logic [1:0] full_stalled;
    logic       ovf_end;
    int         frames_end;
  } vec_t;

  exp_t       q[$];
  vec_t       vt[6];
  logic [1:0] m_full;
  logic       m_wr, m_rd, m_ovf;
  int         m_wr_cnt, m_frames;
  logic       hold_pending, held_l;
  logic [DW-1:0] held_s;
  int         cyc, wrap_cyc, ov_cyc;
  bit         seen_wrap, seen_ov;
  int         n_vec, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear(input bit hard);
    q.delete();
    m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0; m_wr_cnt = 0; m_ovf = 1'b0;
    hold_pending = 1'b0; seen_wrap = 1'b0; seen_ov = 1'b0;
    if (hard) m_frames = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_out_sample"}, 32'(out_sample), 0);
    chk({tag, "_bank_full"}, 32'(bank_full), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  // One clock cycle: drive at negedge, check and update the model mid-cycle.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    exp_t e;
    in_valid = v; in_sample = d; out_ready = rdy; flush = fl;
    #1;
    chk("bank_full", 32'(bank_full), 32'(m_full));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frames_done", 32'(frames_done), 32'(m_frames & 32'hFFFF));
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sample", 32'(out_sample), 32'(held_s));
      chk("hold_last", 32'(out_last), 32'(held_l));
    end
    if (out_valid && !seen_ov) begin seen_ov = 1'b1; ov_cyc = cyc; end
    if (fl) begin
      model_clear(1'b0);
    end else begin
      if (v) begin
        if (!m_full[m_wr]) begin
          e.d = d; e.last = (m_wr_cnt == FL - 1);
          q.push_back(e);
          if (e.last) begin
            m_full[m_wr] = 1'b1; m_wr = ~m_wr; m_wr_cnt = 0;
            if (!seen_wrap) begin seen_wrap = 1'b1; wrap_cyc = cyc; end
          end else m_wr_cnt++;
        end else m_ovf = 1'b1;
      end
      if (out_valid && rdy) begin
        if (q.size() == 0) chk("pop_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_sample", 32'(out_sample), 32'(e.d));
          chk("out_last", 32'(out_last), 32'(e.last));
          if (e.last) begin m_full[m_rd] = 1'b0; m_rd = ~m_rd; m_frames++; end
        end
      end
      hold_pending = out_valid && !rdy;
      held_s = out_sample; held_l = out_last;
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic rdy_for(input int mode, input int c, input bit draining);
    if (mode == 0) return 1'b1;
    if (mode == 1) return draining;
    return c[0];
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; m_frames = 0; wrap_cyc = 0; ov_cyc = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
    model_clear(1'b1);
    vt[0] = '{256, 0, 0, 2'b00, 1'b0, 1};
    vt[1] = '{512, 0, 0, 2'b00, 1'b0, 3};
    vt[2] = '{768, 1, 0, 2'b11, 1'b1, 5};
    vt[3] = '{256, 2, 0, 2'b00, 1'b0, 6};
    vt[4] = '{256, 0, 1, 2'b00, 1'b0, 7};
    vt[5] = '{256, 0, 2, 2'b00, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_frames_done", 32'(frames_done), 0);
    reset = 1'b0;

    for (int vi = 0; vi < 6; vi++) begin
      bit done;
      cycle(1'b0, '0, 1'b1, 1'b1);
      if (vt[vi].abort != 0) begin
        for (int i = 0; i < 100; i++) cycle(1'b1, DW'(i + 500), 1'b1, 1'b0);
        if (vt[vi].abort == 1) begin
          // Flush with a simultaneous write: the write must be discarded.
          cycle(1'b1, DW'(12'hABC), 1'b1, 1'b1);
          chk_idle_outputs("flush");
        end else begin
          reset = 1'b1;
          #1;
          model_clear(1'b1);
          chk_idle_outputs("midreset");
          chk("midreset_frames_done", 32'(frames_done), 0);
          @(negedge clk);
          reset = 1'b0;
          cyc++;
        end
      end
      for (int i = 0; i < vt[vi].n_in; i++)
        cycle(1'b1, DW'(i + 7 * vi), rdy_for(vt[vi].ready_mode, cyc, 1'b0), 1'b0);
      if (vt[vi].ready_mode == 1) begin
        chk("stalled_bank_full", 32'(bank_full), 32'(vt[vi].full_stalled));
        chk("stalled_overflow", 32'(overflow), 1);
      end
      done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
        if (q.size() == 0 && m_full == 2'b00 && !out_valid) done = 1'b1;
        else cycle(1'b0, '0, rdy_for(vt[vi].ready_mode, cyc, 1'b1), 1'b0);
      end
      chk("drain_done", 32'(done), 1);
      if (seen_wrap && seen_ov) chk("latency", 32'(ov_cyc - wrap_cyc), 3);
      else chk("latency_seen", 32'({seen_wrap, seen_ov}), 32'b11);
      chk("end_frames_done", 32'(frames_done), 32'(vt[vi].frames_end));
      chk("end_overflow", 32'(overflow), 32'(vt[vi].ovf_end));
      chk("end_bank_full", 32'(bank_full), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
